// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-source encodings, opcode/funct constants and the fetch-stage state enum.
package cpu_pkg;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_JUMP = 2'b01;
  localparam logic [1:0] PCSRC_JR   = 2'b10;

  localparam logic [5:0] OPC_RTYPE  = 6'h00;
  localparam logic [5:0] OPC_J      = 6'h02;
  localparam logic [5:0] OPC_JAL    = 6'h03;
  localparam logic [5:0] OPC_BEQ    = 6'h04;

  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_ERR   = 2'd2
  } ifetch_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch stage (master) and instruction memory (slave).
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/ifetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, beq target, j/jal target, jr/jalr register target.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] instr_idx,
  input  logic [1:0]  pc_src,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jump_target;

  assign pc_plus4    = pc + 32'd4;
  assign br_offset   = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign br_target   = pc_plus4 + br_offset;
  assign jump_target = {pc_plus4[31:28], instr_idx, 2'b00};

  // The reserved encoding falls through to the sequential/branch path.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_JUMP: next_pc = jump_target;
      PCSRC_JR:   next_pc = rs_data;
      default:    next_pc = (branch && alu_zero) ? br_target : pc_plus4;
    endcase
  end

  assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, fetches one word per instruction over the imem handshake and holds it for decode.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  ifetch_unit_if.master        imem,
  output logic                 instr_valid,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic [5:0]           funct,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  input  logic                 ex_done,
  input  logic [1:0]           pc_src,
  input  logic                 branch,
  input  logic                 alu_zero,
  input  logic [31:0]          rs_data,
  output logic                 fetch_err
);

  localparam logic [7:0] TIMEOUT_CNT = FETCH_TIMEOUT[7:0];

  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    cnt_inc;
  logic [31:0]   next_pc;
  logic          misaligned;

  next_pc_calc u_next_pc (
    .pc         (pc_q),
    .instr_idx  (instr_q[25:0]),
    .pc_src     (pc_src),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .rs_data    (rs_data),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IF_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IF_FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          cnt_d   = 8'd0;
          state_d = IF_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TIMEOUT_CNT) state_d = IF_ERR;
        end
      end
      IF_HOLD: begin
        if (ex_done) begin
          if (misaligned) begin
            state_d = IF_ERR;
          end else begin
            pc_d    = next_pc;
            cnt_d   = 8'd0;
            state_d = IF_FETCH;
          end
        end
      end
      IF_ERR:  state_d = IF_ERR;
      default: state_d = IF_ERR;
    endcase
  end

  // Gating with reset drops the request the moment reset asserts, not at the next edge.
  assign imem.imem_req  = (state_q == IF_FETCH) && reset;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == IF_HOLD);
  assign fetch_err      = (state_q == IF_ERR);
  assign instr          = instr_q;
  assign opcode         = instr_q[31:26];
  assign funct          = instr_q[5:0];
  assign pc             = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized self-checking bench for ifetch_unit against a transaction-level PC model.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FT     = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifetch_unit_if imem_bus ();

  logic        ex_done;
  logic [1:0]  pc_src;
  logic        branch, alu_zero;
  logic [31:0] rs_data;
  logic        instr_valid, fetch_err;
  logic [31:0] instr, pc, pc_plus4;
  logic [5:0]  opcode, funct;

  ifetch_unit #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(FT)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus.master),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ex_done     (ex_done),
    .pc_src      (pc_src),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .fetch_err   (fetch_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instr;
  bit          model_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("req_after_release", 32'(imem_bus.imem_req), 32'd1);
    check("addr_after_release", imem_bus.imem_addr, RST_PC);
    step();
    model_pc  = RST_PC;
    model_err = 1'b0;
  endtask

  task automatic do_reset();
    #3 reset = 1'b0;
    #1;
    check("req_in_reset", 32'(imem_bus.imem_req), 32'd0);
    check("pc_in_reset", pc, RST_PC);
    check("valid_in_reset", 32'(instr_valid), 32'd0);
    check("err_in_reset", 32'(fetch_err), 32'd0);
    check("instr_in_reset", instr, 32'd0);
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = $urandom;
    step();
    check("valid_ready_in_reset", 32'(instr_valid), 32'd0);
    imem_bus.imem_ready = 1'b0;
    release_reset();
  endtask

  // Fetch at model_pc with dly wait cycles; stray ex_done pulses meanwhile must be ignored.
  task automatic fetch(input int dly, input logic [31:0] word);
    check("req", 32'(imem_bus.imem_req), 32'd1);
    check("addr", imem_bus.imem_addr, model_pc);
    check("valid_pre", 32'(instr_valid), 32'd0);
    for (int i = 0; i < dly; i++) begin
      ex_done  = 1'($urandom_range(0, 1));
      pc_src   = PCSRC_JR;
      rs_data  = $urandom & ~32'h3;
      branch   = 1'b1;
      alu_zero = 1'b1;
      step();
      ex_done = 1'b0;
      check("addr_wait", imem_bus.imem_addr, model_pc);
    end
    ex_done             = 1'b0;
    imem_bus.imem_ready = 1'b1;
    imem_bus.imem_rdata = word;
    #2;
    check("valid_latency", 32'(instr_valid), 32'd0);
    step();
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = $urandom;
    model_instr = word;
    check("valid", 32'(instr_valid), 32'd1);
    check("instr", instr, word);
    check("pc", pc, model_pc);
    check("pc_plus4", pc_plus4, model_pc + 32'd4);
    check("opcode", 32'(opcode), word >> 26);
    check("funct", 32'(funct), word & 32'h3F);
    check("req_hold", 32'(imem_bus.imem_req), 32'd0);
  endtask

  task automatic retire(input logic [1:0] src, input logic br, input logic z,
                        input logic [31:0] rs, input int idle);
    logic [31:0] p4, exp_pc;
    int          off;
    for (int i = 0; i < idle; i++) begin
      imem_bus.imem_ready = 1'($urandom_range(0, 1));
      imem_bus.imem_rdata = $urandom;
      step();
      check("instr_stable", instr, model_instr);
      check("valid_idle", 32'(instr_valid), 32'd1);
    end
    imem_bus.imem_ready = 1'b0;
    p4  = model_pc + 32'd4;
    off = $signed(model_instr[15:0]);
    case (src)
      2'b01:   exp_pc = (p4 & 32'hF000_0000) | ((model_instr & 32'h03FF_FFFF) << 2);
      2'b10:   exp_pc = rs;
      default: exp_pc = (br && z) ? p4 + 32'(off * 4) : p4;
    endcase
    ex_done = 1'b1; pc_src = src; branch = br; alu_zero = z; rs_data = rs;
    step();
    ex_done = 1'b0; pc_src = 2'($urandom); branch = 1'($urandom); alu_zero = 1'($urandom);
    rs_data = $urandom;
    if (exp_pc[1:0] != 2'b00) begin
      check("err_misaligned", 32'(fetch_err), 32'd1);
      check("req_err", 32'(imem_bus.imem_req), 32'd0);
      check("valid_err", 32'(instr_valid), 32'd0);
      check("pc_err", pc, model_pc);
      model_err = 1'b1;
    end else begin
      model_pc = exp_pc;
      check("req_redirect", 32'(imem_bus.imem_req), 32'd1);
      check("addr_redirect", imem_bus.imem_addr, exp_pc);
      check("valid_redirect", 32'(instr_valid), 32'd0);
      check("err_redirect", 32'(fetch_err), 32'd0);
    end
  endtask

  task automatic err_hold(input int n);
    for (int i = 0; i < n; i++) begin
      imem_bus.imem_ready = 1'b1;
      ex_done             = 1'($urandom_range(0, 1));
      step();
      check("err_sticky", 32'(fetch_err), 32'd1);
      check("req_sticky", 32'(imem_bus.imem_req), 32'd0);
      check("valid_sticky", 32'(instr_valid), 32'd0);
    end
    imem_bus.imem_ready = 1'b0;
    ex_done             = 1'b0;
  endtask

  // Entered right after a redirect: FT request cycles without ready must end in the error state.
  task automatic timeout_check();
    imem_bus.imem_ready = 1'b0;
    for (int i = 0; i < FT - 1; i++) begin
      step();
      check("req_before_timeout", 32'(imem_bus.imem_req), 32'd1);
    end
    step();
    check("err_timeout", 32'(fetch_err), 32'd1);
    check("req_timeout", 32'(imem_bus.imem_req), 32'd0);
    model_err = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs;
    reset = 1'b1; ex_done = 1'b0; pc_src = 2'b00; branch = 1'b0; alu_zero = 1'b0; rs_data = 32'd0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = 32'd0;
    model_err = 1'b0; model_pc = RST_PC; model_instr = 32'd0;
    #2 reset = 1'b0;
    step(); step();
    check("rst_req", 32'(imem_bus.imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'd0);
    release_reset();

    // Sequential fetches
    fetch(0, 32'h0000_0020); retire(2'b00, 1'b0, 1'b0, 32'd0, 0);
    fetch(0, 32'h0000_0020); retire(2'b00, 1'b0, 1'b0, 32'd0, 1);
    fetch(0, 32'h0000_0020);
    // beq backwards taken / not taken from 0x10
    retire(2'b10, 1'b0, 1'b0, 32'h0000_0010, 0);
    fetch(1, 32'h1000_FFFC); retire(2'b00, 1'b1, 1'b1, 32'd0, 0);
    check("beq_taken", model_pc, 32'h0000_0004);
    fetch(0, 32'h2000_0000); retire(2'b10, 1'b0, 1'b0, 32'h0000_0010, 0);
    fetch(0, 32'h1000_FFFC); retire(2'b00, 1'b1, 1'b0, 32'd0, 0);
    check("beq_not_taken", imem_bus.imem_addr, 32'h0000_0014);
    // j from 0x1000_0000
    fetch(0, $urandom); retire(2'b10, 1'b0, 1'b0, 32'h1000_0000, 0);
    fetch(0, 32'h0810_0000); retire(2'b01, 1'b0, 1'b0, 32'd0, 0);
    check("jump_target", imem_bus.imem_addr, 32'h1040_0000);
    // misaligned jr, then aligned jr
    fetch(0, $urandom); retire(2'b10, 1'b0, 1'b0, 32'h0000_0102, 0);
    err_hold(3); do_reset();
    fetch(0, $urandom); retire(2'b10, 1'b0, 1'b0, 32'h0000_0100, 0);
    fetch(2, $urandom);
    // Timeout boundary: FT-1 wait cycles succeeds, FT fails
    retire(2'b00, 1'b0, 1'b0, 32'd0, 0);
    fetch(FT - 1, $urandom); retire(2'b00, 1'b0, 1'b0, 32'd0, 0);
    timeout_check(); err_hold(2); do_reset();
    // Reset mid-fetch
    fetch(1, $urandom); retire(2'b00, 1'b0, 1'b0, 32'd0, 0);
    do_reset();
    // PC wrap
    fetch(0, $urandom); retire(2'b10, 1'b0, 1'b0, 32'hFFFF_FFFC, 0);
    fetch(0, 32'h0000_0000); retire(2'b00, 1'b0, 1'b0, 32'd0, 0);
    check("pc_wrap", imem_bus.imem_addr, 32'h0000_0000);

    for (int n = 0; n < 300; n++) begin
      if (model_err) begin
        err_hold(1);
        do_reset();
      end
      fetch($urandom_range(0, FT - 3), $urandom);
      case ($urandom_range(0, 3))
        0:       rs = $urandom;
        1:       rs = 32'hFFFF_FFFC;
        default: rs = $urandom & ~32'h3;
      endcase
      retire(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), rs, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
